aes_dec_key_sequencer: RTL and testbench



---
 rtl/aes_pkg.sv | 93 +++++++++
 rtl/aes_key_word_step.sv | 41 ++++
 rtl/aes_dec_key_sequencer.sv | 154 +++++++++++++++
 tb/tb_aes_dec_key_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// +----------------------------------------------------------------------------+
// | aes_pkg: shared constants, FSM encoding and GF(2^8) helpers for the        |
// |          AES decryption key sequencer.                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

    localparam logic [1:0] ALG_128  = 2'b00;
    localparam logic [1:0] ALG_192  = 2'b01;
    localparam logic [1:0] ALG_256  = 2'b10;
    localparam logic [1:0] ALG_RSVD = 2'b11;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam int         WORDS     = 60;
    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        EXPAND = ST_EXPAND,
        READY  = ST_READY,
        STREAM = ST_STREAM
    } state_e;

    function automatic logic [3:0] alg_nk(input logic [1:0] alg);
        case (alg)
            ALG_128: return NK_128;
            ALG_192: return NK_192;
            ALG_256: return NK_256;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] alg_nr(input logic [1:0] alg);
        case (alg)
            ALG_128: return NR_128;
            ALG_192: return NR_192;
            ALG_256: return NR_256;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_word_step.sv
// +----------------------------------------------------------------------------+
// | aes_key_word_step: one combinational AES key-expansion word step.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_key_word_step
    import aes_pkg::*;
(
    input  logic [31:0] w_prev,
    input  logic [31:0] w_nk,
    input  logic [7:0]  rcon,
    input  logic        rot_sub,
    input  logic        sub_only,
    output logic [31:0] w_new
);

    logic [31:0] src;
    logic [31:0] sub;
    logic [31:0] temp;

    assign src = rot_sub ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign sub[8*b +: 8] = sbox(src[8*b +: 8]);
    end

    always_comb begin
        temp = w_prev;
        if (rot_sub) begin
            temp = sub ^ {rcon, 24'h000000};
        end else if (sub_only) begin
            temp = sub;
        end
    end

    assign w_new = w_nk ^ temp;

endmodule

`default_nettype wire

// File: rtl/aes_dec_key_sequencer.sv
// +----------------------------------------------------------------------------+
// | aes_dec_key_sequencer: word-serial AES key expansion with reverse-order    |
// |                        round-key streaming for the inverse cipher.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_dec_key_sequencer
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] key,
    input  logic [1:0]   Algorithm,
    input  logic         key_load,
    output logic         key_busy,
    output logic         key_ready,
    output logic         key_err,
    output logic [3:0]   nr,
    input  logic         dec_start,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    state_e      state_q, state_d;
    logic [3:0]  nk_q, nk_d;
    logic [3:0]  nr_q, nr_d;
    logic [5:0]  idx_q, idx_d;
    logic [2:0]  pos_q, pos_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [3:0]  rnd_q, rnd_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [0:WORDS-1];

    logic        load_go;
    logic [5:0]  idx_last;
    logic [31:0] w_prev, w_nk, w_new;
    logic        rot_sub, sub_only;

    assign idx_last = {nr_q, 2'b11};
    assign w_prev   = mem_q[idx_q - 6'd1];
    assign w_nk     = mem_q[idx_q - {2'b00, nk_q}];
    assign rot_sub  = (pos_q == 3'd0);
    assign sub_only = (nk_q == NK_256) && (pos_q == 3'd4);

    aes_key_word_step u_step (
        .w_prev   (w_prev),
        .w_nk     (w_nk),
        .rcon     (rcon_q),
        .rot_sub  (rot_sub),
        .sub_only (sub_only),
        .w_new    (w_new)
    );

    always_comb begin
        state_d = state_q;
        nk_d    = nk_q;
        nr_d    = nr_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        rcon_d  = rcon_q;
        rnd_d   = rnd_q;
        err_d   = 1'b0;
        load_go = 1'b0;
        case (state_q)
            IDLE, READY: begin
                // A load outranks a simultaneous dec_start in READY.
                if (key_load) begin
                    if (Algorithm == ALG_RSVD) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        nk_d    = 4'd0;
                        nr_d    = 4'd0;
                    end else begin
                        load_go = 1'b1;
                        nk_d    = alg_nk(Algorithm);
                        nr_d    = alg_nr(Algorithm);
                        idx_d   = {2'b00, nk_d};
                        pos_d   = 3'd0;
                        rcon_d  = RCON_INIT;
                        state_d = EXPAND;
                    end
                end else if (state_q == READY && dec_start) begin
                    rnd_d   = nr_q;
                    state_d = STREAM;
                end
            end
            EXPAND: begin
                idx_d = idx_q + 6'd1;
                pos_d = ({1'b0, pos_q} == nk_q - 4'd1) ? 3'd0 : pos_q + 3'd1;
                if (rot_sub) rcon_d = xtime(rcon_q);
                if (idx_q == idx_last) state_d = READY;
            end
            STREAM: begin
                if (rk_ready) begin
                    if (rnd_q == 4'd0) state_d = READY;
                    else               rnd_d   = rnd_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nk_q    <= 4'd0;
            nr_q    <= 4'd0;
            idx_q   <= 6'd0;
            pos_q   <= 3'd0;
            rcon_q  <= RCON_INIT;
            rnd_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nk_q    <= nk_d;
            nr_q    <= nr_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            rcon_q  <= rcon_d;
            rnd_q   <= rnd_d;
            err_q   <= err_d;
        end
    end

    // Schedule storage is deliberately left unreset; only written words are ever read.
    always_ff @(posedge clk) begin
        if (load_go) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(nk_d)) mem_q[k] <= key[255-32*k -: 32];
            end
        end else if (state_q == EXPAND) begin
            mem_q[idx_q] <= w_new;
        end
    end

    assign key_busy  = (state_q == EXPAND);
    assign key_ready = (state_q == READY) || (state_q == STREAM);
    assign key_err   = err_q;
    assign nr        = nr_q;
    assign rk_valid  = (state_q == STREAM);
    assign rk_round  = rk_valid ? rnd_q : 4'd0;
    assign rk_last   = rk_valid && (rnd_q == 4'd0);
    assign rk_data   = rk_valid ? {mem_q[{rnd_q, 2'b00}], mem_q[{rnd_q, 2'b01}],
                                   mem_q[{rnd_q, 2'b10}], mem_q[{rnd_q, 2'b11}]}
                                : 128'h0;

endmodule

`default_nettype wire

// File: tb/tb_aes_dec_key_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_aes_dec_key_sequencer: randomized self-checking bench with a FIPS-197   |
// |                           key-schedule reference model.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_aes_dec_key_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key;
    logic [1:0]   alg;
    logic         key_load, dec_start, rk_ready;
    logic         key_busy, key_ready, key_err, rk_valid, rk_last;
    logic [3:0]   nr, rk_round;
    logic [127:0] rk_data;

    int n_tot = 0;
    int n_bad = 0;

    logic [7:0] sbox_t [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    logic [7:0] rcon_t [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [31:0]  ref_w [0:59];
    int           ref_nr;
    logic [255:0] loaded_key;

    aes_dec_key_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .Algorithm (alg),
        .key_load  (key_load),
        .key_busy  (key_busy),
        .key_ready (key_ready),
        .key_err   (key_err),
        .nr        (nr),
        .dec_start (dec_start),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_data   (rk_data),
        .rk_round  (rk_round),
        .rk_last   (rk_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Textbook FIPS-197 KeyExpansion on a flat word array.
    task automatic model_expand(input logic [255:0] k, input logic [1:0] a);
        int nk;
        logic [31:0] t;
        nk     = 4 + 2 * int'(a);
        ref_nr = nk + 6;
        for (int i = 0; i < nk; i++) ref_w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4 * (ref_nr + 1); i++) begin
            t = ref_w[i-1];
            if (i % nk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk - 1], 24'h0};
            else if (nk == 8 && i % nk == 4)
                t = subw(t);
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    task automatic check_reset_outs(input string tag);
        chk({tag, "_busy"},  128'(key_busy),  128'd0);
        chk({tag, "_ready"}, 128'(key_ready), 128'd0);
        chk({tag, "_err"},   128'(key_err),   128'd0);
        chk({tag, "_valid"}, 128'(rk_valid),  128'd0);
        chk({tag, "_last"},  128'(rk_last),   128'd0);
        chk({tag, "_nr"},    128'(nr),        128'd0);
        chk({tag, "_round"}, 128'(rk_round),  128'd0);
        chk({tag, "_data"},  rk_data,         128'd0);
    endtask

    task automatic run_load(input logic [255:0] k, input logic [1:0] a, input string tag);
        int cnt;
        int nk;
        model_expand(k, a);
        nk         = 4 + 2 * int'(a);
        loaded_key = k;
        key        = k;
        alg        = a;
        key_load   = 1'b1;
        tick;
        key_load   = 1'b0;
        chk({tag, "_ready_low_in_expand"}, 128'(key_ready), 128'd0);
        cnt = 0;
        while (key_busy === 1'b1 && cnt < 100) begin
            dec_start = (cnt == 3);
            cnt++;
            tick;
        end
        dec_start = 1'b0;
        chk({tag, "_busy_cycles"}, 128'(cnt), 128'(4 * (ref_nr + 1) - nk));
        chk({tag, "_ready"},       128'(key_ready), 128'd1);
        chk({tag, "_nr"},          128'(nr), 128'(ref_nr));
        chk({tag, "_no_stream_from_expand"}, 128'(rk_valid), 128'd0);
    endtask

    task automatic run_stream(input bit bp, input bit inject, input bit has_kat,
                              input logic [127:0] kat, input string tag);
        int   exp_r;
        int   beats;
        int   guard;
        bit   injected;
        logic hs;
        exp_r    = ref_nr;
        beats    = 0;
        guard    = 0;
        injected = 1'b0;
        dec_start = 1'b1;
        tick;
        dec_start = 1'b0;
        while (exp_r >= 0 && guard < 400) begin
            guard++;
            rk_ready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
            if (inject && !injected && beats == 3) begin
                key      = ~key;
                alg      = 2'b00;
                key_load = 1'b1;
                injected = 1'b1;
            end else begin
                key_load = 1'b0;
            end
            chk({tag, "_valid"}, 128'(rk_valid),  128'd1);
            chk({tag, "_round"}, 128'(rk_round),  128'(exp_r));
            chk({tag, "_data"},  rk_data,         ref_rk(exp_r));
            chk({tag, "_last"},  128'(rk_last),   128'(exp_r == 0));
            chk({tag, "_kready"}, 128'(key_ready), 128'd1);
            if (has_kat && exp_r == ref_nr) chk({tag, "_first_kat"}, rk_data, kat);
            if (exp_r == 0) chk({tag, "_last_eq_key"}, rk_data, loaded_key[255:128]);
            hs = rk_valid && rk_ready;
            tick;
            if (hs) begin
                beats++;
                exp_r--;
            end
        end
        key_load = 1'b0;
        rk_ready = 1'b1;
        chk({tag, "_handshakes"},  128'(beats), 128'(ref_nr + 1));
        chk({tag, "_valid_after"}, 128'(rk_valid), 128'd0);
        chk({tag, "_ready_after"}, 128'(key_ready), 128'd1);
        chk({tag, "_busy_after"},  128'(key_busy), 128'd0);
    endtask

    task automatic reset_mid(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check_reset_outs({tag, "_post"});
    endtask

    task automatic rand_key(output logic [255:0] k);
        for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    endtask

    initial begin
        logic [255:0] rk;
        rst_n     = 1'b0;
        key       = '0;
        alg       = 2'b00;
        key_load  = 1'b0;
        dec_start = 1'b0;
        rk_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check_reset_outs("reset");

        dec_start = 1'b1;
        tick;
        dec_start = 1'b0;
        chk("dec_start_in_idle", 128'(rk_valid), 128'd0);

        run_load(K128, 2'b00, "aes128");
        run_stream(1'b0, 1'b0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_s");
        run_load(K192, 2'b01, "aes192");
        run_stream(1'b0, 1'b0, 1'b1, 128'he98ba06f448c773c8ecc720401002202, "aes192_s");
        run_load(K256, 2'b10, "aes256");
        run_stream(1'b0, 1'b0, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e, "aes256_s");

        rand_key(rk);
        key      = rk;
        alg      = 2'b11;
        key_load = 1'b1;
        tick;
        key_load = 1'b0;
        chk("rsvd_err",   128'(key_err),   128'd1);
        chk("rsvd_ready", 128'(key_ready), 128'd0);
        chk("rsvd_busy",  128'(key_busy),  128'd0);
        dec_start = 1'b1;
        tick;
        dec_start = 1'b0;
        chk("rsvd_err_pulse", 128'(key_err),  128'd0);
        chk("rsvd_no_stream", 128'(rk_valid), 128'd0);

        run_load(K128, 2'b00, "bp128");
        run_stream(1'b1, 1'b0, 1'b0, 128'd0, "bp128_s");

        for (int n = 0; n < 3; n++) begin
            rand_key(rk);
            run_load(rk, 2'($urandom_range(2, 0)), $sformatf("rnd%0d", n));
            run_stream(1'b1, n == 1, 1'b0, 128'd0, $sformatf("rnd%0d_s", n));
        end

        key      = K128;
        alg      = 2'b00;
        key_load = 1'b1;
        tick;
        key_load = 1'b0;
        repeat (10) tick;
        reset_mid("rst_expand");

        rand_key(rk);
        run_load(rk, 2'b10, "pre_rst");
        dec_start = 1'b1;
        tick;
        dec_start = 1'b0;
        repeat (3) tick;
        reset_mid("rst_stream");

        run_load(K128, 2'b00, "again128");
        run_stream(1'b0, 1'b0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "again128_s");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
